// File: rtl/rf_wport_scheduler_pkg.sv
// Shared definitions for the register-file write-port scheduler.
package rf_wport_scheduler_pkg;

  // Scheduler operating mode: zero-clearing the RF, or servicing lane requests.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_t;

  localparam int unsigned RF_DEF_MEMD  = 16;
  localparam int unsigned RF_DEF_DATAW = 64;

  // Width of an index that can name any of n items (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wport_scheduler_rr_multi_grant.sv
// Rotating-priority picker: grants up to nWPORTS candidate lanes per cycle,
// scanning from i_ptr and wrapping modulo nREQ.
module rr_multi_grant
  import rf_wport_scheduler_pkg::*;
#(
  parameter int unsigned nREQ    = 4,
  parameter int unsigned nWPORTS = 2,
  parameter int unsigned PTRW    = idx_width(nREQ)
) (
  input  logic [nREQ-1:0]         i_cand,
  input  logic [PTRW-1:0]         i_ptr,
  output logic [nREQ-1:0]         o_grant,
  output logic [nWPORTS-1:0]      o_port_vld,
  output logic [nWPORTS*PTRW-1:0] o_port_lane,
  output logic [PTRW-1:0]         o_next_ptr
);

  localparam int unsigned PW = idx_width(nWPORTS);

  logic [PTRW-1:0] w_lane [nWPORTS];

  // Walk the lanes in rotated order; the k-th granted lane lands on port k.
  always_comb begin : p_pick
    int unsigned     cnt;
    logic [PTRW-1:0] idx;
    logic [PTRW-1:0] last;
    logic            any;
    o_grant    = '0;
    o_port_vld = '0;
    for (int unsigned k = 0; k < nWPORTS; k++) w_lane[k] = '0;
    cnt  = 0;
    idx  = '0;
    last = '0;
    any  = 1'b0;
    for (int unsigned off = 0; off < nREQ; off++) begin
      idx = PTRW'((32'(i_ptr) + off) % nREQ);
      if (i_cand[idx] && (cnt < nWPORTS)) begin
        o_grant[idx]           = 1'b1;
        o_port_vld[cnt[PW-1:0]] = 1'b1;
        w_lane[cnt[PW-1:0]]     = idx;
        cnt  = cnt + 1;
        last = idx;
        any  = 1'b1;
      end
    end
    o_next_ptr = any ? PTRW'((32'(last) + 1) % nREQ) : i_ptr;
  end

  for (genvar g = 0; g < nWPORTS; g++) begin : g_pack
    assign o_port_lane[g*PTRW +: PTRW] = w_lane[g];
  end

endmodule

// File: rtl/rf_wport_scheduler.sv
// Write-port scheduler for the multi-ported register file and its LVT:
// coalesces same-address lane requests, shares ports round-robin, and
// zero-clears the whole RF after reset.
module rf_wport_scheduler
  import rf_wport_scheduler_pkg::*;
#(
  parameter int unsigned MEMD           = RF_DEF_MEMD,
  parameter int unsigned DATAW          = RF_DEF_DATAW,
  parameter int unsigned nREQ           = 4,
  parameter int unsigned nWPORTS        = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned ADDRW          = $clog2(MEMD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [nREQ-1:0]          req_valid,
  input  logic [ADDRW*nREQ-1:0]    req_addr,
  input  logic [DATAW*nREQ-1:0]    req_data,
  output logic [nREQ-1:0]          req_ready,
  output logic [nWPORTS-1:0]       WEnb,
  output logic [ADDRW*nWPORTS-1:0] WAddr,
  output logic [DATAW*nWPORTS-1:0] WData,
  output logic                     init_busy
);

  localparam int unsigned PTRW = idx_width(nREQ);

  rf_state_t                r_state, w_state_nxt;
  logic [ADDRW-1:0]         r_clr_cnt, w_clr_nxt;
  logic [PTRW-1:0]          r_rr_ptr;
  logic                     r_busy;
  logic [nWPORTS-1:0]       r_wenb, w_wenb_nxt;
  logic [ADDRW*nWPORTS-1:0] r_waddr, w_waddr_nxt;
  logic [DATAW*nWPORTS-1:0] r_wdata, w_wdata_nxt;

  logic [ADDRW-1:0]         w_laddr [nREQ];
  logic [DATAW-1:0]         w_ldata [nREQ];
  logic [PTRW-1:0]          w_plane [nWPORTS];
  logic [nREQ-1:0]          w_super;
  logic [nREQ-1:0]          w_cand;
  logic [nREQ-1:0]          w_grant;
  logic [nWPORTS-1:0]       w_port_vld;
  logic [nWPORTS*PTRW-1:0]  w_port_lane;
  logic [PTRW-1:0]          w_next_ptr;

  for (genvar g = 0; g < nREQ; g++) begin : g_lane
    assign w_laddr[g] = req_addr[g*ADDRW +: ADDRW];
    assign w_ldata[g] = req_data[g*DATAW +: DATAW];
  end

  for (genvar g = 0; g < nWPORTS; g++) begin : g_port
    assign w_plane[g] = w_port_lane[g*PTRW +: PTRW];
  end

  // Coalesce: a valid lane loses to any later valid lane with the same address.
  always_comb begin
    w_super = '0;
    for (int unsigned i = 0; i < nREQ; i++) begin
      for (int unsigned j = i + 1; j < nREQ; j++) begin
        if (req_valid[i] && req_valid[j] && (w_laddr[i] == w_laddr[j])) w_super[i] = 1'b1;
      end
    end
  end

  assign w_cand = ((r_state == ST_RUN) && !rst) ? (req_valid & ~w_super) : '0;

  rr_multi_grant #(
    .nREQ    (nREQ),
    .nWPORTS (nWPORTS),
    .PTRW    (PTRW)
  ) u_pick (
    .i_cand      (w_cand),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_port_vld  (w_port_vld),
    .o_port_lane (w_port_lane),
    .o_next_ptr  (w_next_ptr)
  );

  // Ack granted lanes and any lane superseded by a lane granted this cycle.
  always_comb begin
    req_ready = w_grant;
    for (int unsigned i = 0; i < nREQ; i++) begin
      for (int unsigned j = i + 1; j < nREQ; j++) begin
        if (w_super[i] && req_valid[j] && (w_laddr[i] == w_laddr[j]) && w_grant[j])
          req_ready[i] = 1'b1;
      end
    end
  end

  // Next state and clear address.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_clr_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == ADDRW'(MEMD - 1)) begin
          w_state_nxt = ST_RUN;
          w_clr_nxt   = '0;
        end
      end
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // Next values of the write-port registers: a clear write, or the granted lanes.
  always_comb begin
    w_wenb_nxt  = '0;
    w_waddr_nxt = '0;
    w_wdata_nxt = '0;
    if (r_state == ST_CLEAR) begin
      w_wenb_nxt[0]           = 1'b1;
      w_waddr_nxt[ADDRW-1:0]  = r_clr_cnt;
    end else begin
      for (int unsigned k = 0; k < nWPORTS; k++) begin
        if (w_port_vld[k]) begin
          w_wenb_nxt[k]                  = 1'b1;
          w_waddr_nxt[k*ADDRW +: ADDRW]  = w_laddr[w_plane[k]];
          w_wdata_nxt[k*DATAW +: DATAW]  = w_ldata[w_plane[k]];
        end
      end
    end
  end

  // State, clear counter, round-robin pointer and registered write ports.
  // init_busy is registered so it stays high for the cycle in which the last
  // clear write is on the ports, i.e. it covers every visible clear write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_clr_cnt <= '0;
      r_rr_ptr  <= '0;
      r_busy    <= CLEAR_ON_RESET;
      r_wenb    <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_nxt;
      r_busy    <= (r_state == ST_CLEAR);
      r_wenb    <= w_wenb_nxt;
      r_waddr   <= w_waddr_nxt;
      r_wdata   <= w_wdata_nxt;
      if (r_state == ST_RUN) r_rr_ptr <= w_next_ptr;
    end
  end

  assign WEnb      = r_wenb;
  assign WAddr     = r_waddr;
  assign WData     = r_wdata;
  assign init_busy = r_busy;

endmodule
